thumb_decode_stage: RTL and testbench
=====================================

Name: thumb_decode_stage

Overview:
- Registered Thumb-16 decode stage with a parametrised input halfword buffer and valid/ready handshakes on both sides.
- Completes the full subset: ADD, SUB, MOV, CMP, LSL, EOR, LDR, STR, B, Bcond, SVC.
- Adds two-halfword BL handling, flush, and a write-enable output.
- Sits between fetch and register-read/execute.

Parameters:
- DEPTH, 2, input FIFO entries (≥1); power of two not required.
- UOP_W, 5, uop width (≥4).
- NUM_W, 32, immediate/offset width (≥24).
- SEL_W, 4, register-select width (≥4; r14=LR must be encodable).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers in_instr.
- in_ready  out  1  buffer can accept; equals (count < DEPTH); no same-cycle pop bypass.
- in_instr  in  16  Thumb halfword.
- flush  in  1  discard buffer, output register and BL state.
- out_valid  out  1  decoded uop held in output register.
- out_ready  in  1  consumer accepts uop.
- uop  out  UOP_W  0 NOP, 1 ADD, 2 SUB, 3 MOV, 4 CMP, 5 EOR, 6 LSL, 7 LDR, 8 STR, 9 B, 10 BCOND, 11 BL, 12 SVC, all-ones UNDEF.
- num_to_rhs  out  1  num replaces the sel_p0 operand.
- num  out  NUM_W  zero-extended immediate or sign-extended byte offset.
- sel_p0 / sel_p1 / sel_in  out  SEL_W each  operand / destination registers.
- wr_en  out  1  sel_in is written.
- cond  out  4  condition for BCOND, else 4'hE.
- explose  out  1  undefined/unsupported encoding; uop is UNDEF.

Behaviour:
- Reset (async, rst_n low): FIFO empty, state NORMAL, out_valid=0, all payload outputs 0, cond=0, in_ready=1 after release.
- Push when in_valid & in_ready. Pop when FIFO non-empty and (!out_valid | out_ready).
- Each pop is decoded and registered on the same edge.
- Latency: halfword pushed at edge N, out_valid at edge N+1 if the output path is free. Sustained rate 1 uop/cycle with out_ready=1.
- out_valid and payload hold stable until out_ready. The output register is cleared to NOP values only by flush/reset.
- Decode map (Rd=[2:0], Rn=[5:3], Rm=[8:6] unless stated; unlisted fields 0):
  - 0001100 ADD reg: p0=Rm, p1=Rn, in=Rd, wr.
  - 0001101 SUB reg: same fields.
  - 0001110 / 0001111 ADD/SUB imm3: num=[8:6], rhs, p1=Rn, in=Rd, wr.
  - 00000 with imm5=0: MOV reg, p1=Rn, in=Rd, wr.
  - 00000 with imm5≠0: LSL, num=imm5, rhs, p1=Rn, in=Rd, wr.
  - 00100 MOV imm8: num=[7:0], rhs, in=[10:8], wr.
  - 00101 CMP imm8: p1=[10:8], num, rhs, wr=0.
  - 00110 / 00111 ADD/SUB imm8: p1=in=[10:8], num, rhs, wr.
  - 0100000001 EOR: p0=[5:3], p1=in=[2:0], wr.
  - 01101 LDR: num=imm5<<2, rhs, p1=Rn, in=Rd, wr.
  - 01100 STR: same num, rhs, p1=Rn, p0=Rd, wr=0.
  - 11100 B: num=sext(imm11)<<1.
  - 1101 cond<14 BCOND: cond=[11:8], num=sext(imm8)<<1.
  - 11011111 SVC: num=imm8.
  - 11011110 and every other encoding: UNDEF, explose=1.
- BL state machine:
  - NORMAL, pop 11110 prefix: no output; latch hi=sext(imm11)<<12; go WAIT_SUFFIX.
  - WAIT_SUFFIX, head is 11111 suffix: pop; emit BL, num=hi+(imm11<<1), in=14, wr=1; go NORMAL.
  - WAIT_SUFFIX, head is not a suffix: emit UNDEF/explose without popping; head is decoded normally next pop; go NORMAL.
  - Lone suffix in NORMAL: UNDEF.
  - WAIT_SUFFIX with empty FIFO: wait indefinitely.
- Flush: synchronous. Empties FIFO, clears out_valid, returns to NORMAL.
  - A push coinciding with flush is dropped.
  - out_ready coinciding with flush has no effect.
- All offsets wrap modulo 2^NUM_W.

Test Plan:
- Push 0x1842, out_ready=1: next edge out_valid=1, uop=1, sel_p0=1, sel_p1=0, sel_in=2, wr_en=1, explose=0.
- Push 0x235A then 0xD1FE back-to-back: MOV (num=0x5A, sel_in=3, rhs=1), then BCOND (cond=1, num=0xFFFFFFFC), on consecutive cycles.
- Push 0xF000, 0xF802: a single BL uop, num=4, sel_in=14, wr_en=1; also 0xF000, 0x1842: UNDEF/explose, then ADD.
- out_ready=0, push 4 halfwords with DEPTH=2: in_ready low after 3 accepted (1 output + 2 buffered); raise out_ready → all 4 emitted in order, payload stable while stalled.
- Push 0xF000, flush next cycle, push 0x235A: only the MOV is emitted, no UNDEF.
- Push 0xDE00 and 0x4041: UNDEF/explose=1, then EOR with sel_p0=0, sel_in=1; assert rst_n low mid-stream → out_valid=0, outputs 0 immediately.

Source files
------------

// File: rtl/thumb_decode_stage.sv
// Registered Thumb-16 decode stage: small halfword FIFO feeding a one-entry output
// register, with BL prefix/suffix pairing and synchronous flush.
module thumb_decode_stage #(
    parameter int DEPTH = 2,
    parameter int UOP_W = 5,
    parameter int NUM_W = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [UOP_W-1:0] uop,
    output logic             num_to_rhs,
    output logic [NUM_W-1:0] num,
    output logic [SEL_W-1:0] sel_p0,
    output logic [SEL_W-1:0] sel_p1,
    output logic [SEL_W-1:0] sel_in,
    output logic             wr_en,
    output logic [3:0]       cond,
    output logic             explose
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [UOP_W-1:0] UOP_ADD   = UOP_W'(1);
    localparam logic [UOP_W-1:0] UOP_SUB   = UOP_W'(2);
    localparam logic [UOP_W-1:0] UOP_MOV   = UOP_W'(3);
    localparam logic [UOP_W-1:0] UOP_CMP   = UOP_W'(4);
    localparam logic [UOP_W-1:0] UOP_EOR   = UOP_W'(5);
    localparam logic [UOP_W-1:0] UOP_LSL   = UOP_W'(6);
    localparam logic [UOP_W-1:0] UOP_LDR   = UOP_W'(7);
    localparam logic [UOP_W-1:0] UOP_STR   = UOP_W'(8);
    localparam logic [UOP_W-1:0] UOP_B     = UOP_W'(9);
    localparam logic [UOP_W-1:0] UOP_BCOND = UOP_W'(10);
    localparam logic [UOP_W-1:0] UOP_BL    = UOP_W'(11);
    localparam logic [UOP_W-1:0] UOP_SVC   = UOP_W'(12);
    localparam logic [UOP_W-1:0] UOP_UNDEF = {UOP_W{1'b1}};

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic             rhs;
        logic [NUM_W-1:0] num;
        logic [SEL_W-1:0] p0;
        logic [SEL_W-1:0] p1;
        logic [SEL_W-1:0] dst;
        logic             wr;
        logic [3:0]       cond;
        logic             explose;
    } dec_t;

    typedef enum logic {ST_NORMAL = 1'b0, ST_WAIT_SUFFIX = 1'b1} state_t;

    function automatic dec_t undef_uop();
        dec_t d;
        d         = '0;
        d.uop     = UOP_UNDEF;
        d.cond    = 4'hE;
        d.explose = 1'b1;
        return d;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        else return p + PTR_W'(1);
    endfunction

    function automatic dec_t decode(input logic [15:0] i);
        dec_t d;
        d      = '0;
        d.cond = 4'hE;
        casez (i)
            16'b0001_10??_????_????: begin
                d.uop = i[9] ? UOP_SUB : UOP_ADD;
                d.p0  = SEL_W'(i[8:6]);
                d.p1  = SEL_W'(i[5:3]);
                d.dst = SEL_W'(i[2:0]);
                d.wr  = 1'b1;
            end
            16'b0001_11??_????_????: begin
                d.uop = i[9] ? UOP_SUB : UOP_ADD;
                d.num = NUM_W'(i[8:6]);
                d.rhs = 1'b1;
                d.p1  = SEL_W'(i[5:3]);
                d.dst = SEL_W'(i[2:0]);
                d.wr  = 1'b1;
            end
            16'b0000_0???_????_????: begin
                d.p1  = SEL_W'(i[5:3]);
                d.dst = SEL_W'(i[2:0]);
                d.wr  = 1'b1;
                if (i[10:6] == 5'd0) begin
                    d.uop = UOP_MOV;
                end else begin
                    d.uop = UOP_LSL;
                    d.num = NUM_W'(i[10:6]);
                    d.rhs = 1'b1;
                end
            end
            16'b001?_????_????_????: begin
                d.num = NUM_W'(i[7:0]);
                d.rhs = 1'b1;
                case (i[12:11])
                    2'd0: begin d.uop = UOP_MOV; d.dst = SEL_W'(i[10:8]); d.wr = 1'b1; end
                    2'd1: begin d.uop = UOP_CMP; d.p1 = SEL_W'(i[10:8]); end
                    2'd2: begin d.uop = UOP_ADD; d.p1 = SEL_W'(i[10:8]); d.dst = SEL_W'(i[10:8]); d.wr = 1'b1; end
                    default: begin d.uop = UOP_SUB; d.p1 = SEL_W'(i[10:8]); d.dst = SEL_W'(i[10:8]); d.wr = 1'b1; end
                endcase
            end
            16'b0100_0000_01??_????: begin
                d.uop = UOP_EOR;
                d.p0  = SEL_W'(i[5:3]);
                d.p1  = SEL_W'(i[2:0]);
                d.dst = SEL_W'(i[2:0]);
                d.wr  = 1'b1;
            end
            16'b0110_????_????_????: begin
                d.num = NUM_W'(i[10:6]) << 2;
                d.rhs = 1'b1;
                d.p1  = SEL_W'(i[5:3]);
                if (i[11]) begin
                    d.uop = UOP_LDR;
                    d.dst = SEL_W'(i[2:0]);
                    d.wr  = 1'b1;
                end else begin
                    d.uop = UOP_STR;
                    d.p0  = SEL_W'(i[2:0]);
                end
            end
            16'b1110_0???_????_????: begin
                d.uop = UOP_B;
                d.num = {{(NUM_W-11){i[10]}}, i[10:0]} << 1;
            end
            16'b1101_1111_????_????: begin
                d.uop = UOP_SVC;
                d.num = NUM_W'(i[7:0]);
            end
            16'b1101_????_????_????: begin
                // cond 14 (0xDExx) is the permanently-undefined slot, 15 is SVC above
                if (i[11:8] < 4'hE) begin
                    d.uop  = UOP_BCOND;
                    d.cond = i[11:8];
                    d.num  = {{(NUM_W-8){i[7]}}, i[7:0]} << 1;
                end else begin
                    d = undef_uop();
                end
            end
            default: d = undef_uop();
        endcase
        return d;
    endfunction

    logic [15:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    state_t           state_r, state_next_s;
    logic [NUM_W-1:0] hi_r;
    logic             out_valid_r;
    dec_t             out_r, load_val_s;
    logic [15:0]      head_s;
    logic             push_s, pop_s, load_s, latch_hi_s;

    assign in_ready = (count_r < CNT_W'(DEPTH));
    assign push_s   = in_valid & in_ready;
    assign head_s   = mem_r[rd_ptr_r];

    // Pop/load decision and BL pairing next-state.
    always_comb begin
        pop_s        = 1'b0;
        load_s       = 1'b0;
        latch_hi_s   = 1'b0;
        state_next_s = state_r;
        load_val_s   = decode(head_s);
        if ((count_r != CNT_W'(0)) && (!out_valid_r || out_ready)) begin
            case (state_r)
                ST_NORMAL: begin
                    pop_s = 1'b1;
                    if (head_s[15:11] == 5'b11110) begin
                        latch_hi_s   = 1'b1;
                        state_next_s = ST_WAIT_SUFFIX;
                    end else begin
                        load_s = 1'b1;
                    end
                end
                ST_WAIT_SUFFIX: begin
                    load_s       = 1'b1;
                    state_next_s = ST_NORMAL;
                    if (head_s[15:11] == 5'b11111) begin
                        pop_s              = 1'b1;
                        load_val_s         = '0;
                        load_val_s.uop     = UOP_BL;
                        load_val_s.num     = hi_r + (NUM_W'(head_s[10:0]) << 1);
                        load_val_s.dst     = SEL_W'(14);
                        load_val_s.wr      = 1'b1;
                        load_val_s.cond    = 4'hE;
                    end else begin
                        // unpaired prefix: head stays queued and decodes on its own next time
                        load_val_s = undef_uop();
                    end
                end
                default: state_next_s = ST_NORMAL;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FIFO storage; data only, pointers carry validity.
    always_ff @(posedge clk) begin
        if (push_s && !flush) mem_r[wr_ptr_r] <= in_instr;
    end

    // Pointers, occupancy, BL state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            state_r     <= ST_NORMAL;
            hi_r        <= '0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else if (flush) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            state_r     <= ST_NORMAL;
            hi_r        <= '0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            state_r <= state_next_s;
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            if (latch_hi_s) hi_r <= {{(NUM_W-11){head_s[10]}}, head_s[10:0]} << 12;
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_r       <= load_val_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign uop        = out_r.uop;
    assign num_to_rhs = out_r.rhs;
    assign num        = out_r.num;
    assign sel_p0     = out_r.p0;
    assign sel_p1     = out_r.p1;
    assign sel_in     = out_r.dst;
    assign wr_en      = out_r.wr;
    assign cond       = out_r.cond;
    assign explose    = out_r.explose;
endmodule

// File: tb/tb_thumb_decode_stage.sv
// Bench for thumb_decode_stage: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_thumb_decode_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic [4:0]  uop;
    logic        num_to_rhs, wr_en, explose;
    logic [31:0] num;
    logic [3:0]  sel_p0, sel_p1, sel_in, cond;

    thumb_decode_stage #(.DEPTH(DEPTH), .UOP_W(5), .NUM_W(32), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .uop(uop), .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1),
        .sel_in(sel_in), .wr_en(wr_en), .cond(cond), .explose(explose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  uop;
        logic        rhs;
        logic [31:0] num;
        logic [3:0]  p0, p1, dst;
        logic        wr;
        logic [3:0]  cond;
        logic        ex;
    } pay_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] q_m[$];
    bit          ov_m, wait_m;
    logic [31:0] hi_m;
    pay_t        pay_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pay_t zero_pay();
        pay_t p;
        p.uop = 5'd0; p.rhs = 1'b0; p.num = 32'd0; p.p0 = 4'd0; p.p1 = 4'd0;
        p.dst = 4'd0; p.wr = 1'b0; p.cond = 4'd0; p.ex = 1'b0;
        return p;
    endfunction

    function automatic pay_t undef_pay();
        pay_t p = zero_pay();
        p.uop = 5'd31; p.ex = 1'b1; p.cond = 4'hE;
        return p;
    endfunction

    // Reference decoder: field extraction with plain integer arithmetic.
    function automatic pay_t ref_decode(input logic [15:0] h);
        pay_t p = zero_pay();
        int   off;
        p.cond = 4'hE;
        if (h[15:10] == 6'b000110) begin
            p.uop = h[9] ? 5'd2 : 5'd1;
            p.p0 = {1'b0, h[8:6]}; p.p1 = {1'b0, h[5:3]}; p.dst = {1'b0, h[2:0]}; p.wr = 1'b1;
        end else if (h[15:10] == 6'b000111) begin
            p.uop = h[9] ? 5'd2 : 5'd1; p.num = 32'(h[8:6]); p.rhs = 1'b1;
            p.p1 = {1'b0, h[5:3]}; p.dst = {1'b0, h[2:0]}; p.wr = 1'b1;
        end else if (h[15:11] == 5'b00000) begin
            p.p1 = {1'b0, h[5:3]}; p.dst = {1'b0, h[2:0]}; p.wr = 1'b1;
            if (h[10:6] == 5'd0) p.uop = 5'd3;
            else begin p.uop = 5'd6; p.num = 32'(h[10:6]); p.rhs = 1'b1; end
        end else if (h[15:13] == 3'b001) begin
            p.num = 32'(h[7:0]); p.rhs = 1'b1;
            case (h[12:11])
                2'd0: begin p.uop = 5'd3; p.dst = {1'b0, h[10:8]}; p.wr = 1'b1; end
                2'd1: begin p.uop = 5'd4; p.p1 = {1'b0, h[10:8]}; end
                2'd2: begin p.uop = 5'd1; p.p1 = {1'b0, h[10:8]}; p.dst = p.p1; p.wr = 1'b1; end
                default: begin p.uop = 5'd2; p.p1 = {1'b0, h[10:8]}; p.dst = p.p1; p.wr = 1'b1; end
            endcase
        end else if (h[15:6] == 10'b0100000001) begin
            p.uop = 5'd5; p.p0 = {1'b0, h[5:3]}; p.p1 = {1'b0, h[2:0]}; p.dst = p.p1; p.wr = 1'b1;
        end else if (h[15:12] == 4'b0110) begin
            p.num = 32'(h[10:6]) * 32'd4; p.rhs = 1'b1; p.p1 = {1'b0, h[5:3]};
            if (h[11]) begin p.uop = 5'd7; p.dst = {1'b0, h[2:0]}; p.wr = 1'b1; end
            else begin p.uop = 5'd8; p.p0 = {1'b0, h[2:0]}; end
        end else if (h[15:11] == 5'b11100) begin
            off = $signed(h[10:0]); p.uop = 5'd9; p.num = 32'(off * 2);
        end else if (h[15:12] == 4'b1101 && h[11:8] < 4'd14) begin
            off = $signed(h[7:0]); p.uop = 5'd10; p.cond = h[11:8]; p.num = 32'(off * 2);
        end else if (h[15:8] == 8'hDF) begin
            p.uop = 5'd12; p.num = 32'(h[7:0]);
        end else begin
            p = undef_pay();
        end
        return p;
    endfunction

    task automatic model_reset();
        q_m.delete(); ov_m = 1'b0; wait_m = 1'b0; hi_m = 32'd0; pay_m = zero_pay();
    endtask

    // Advance the model by one clock edge given the inputs driven for that edge.
    task automatic model_step(input logic v, input logic [15:0] h, input logic rdy, input logic fl);
        bit          push, loaded;
        logic [15:0] hd;
        int          off;
        if (fl) begin
            model_reset();
            return;
        end
        push = v && (q_m.size() < DEPTH);
        loaded = 1'b0;
        if (q_m.size() > 0 && (!ov_m || rdy)) begin
            hd = q_m[0];
            if (!wait_m) begin
                void'(q_m.pop_front());
                if (hd[15:11] == 5'b11110) begin
                    off = $signed(hd[10:0]); hi_m = 32'(off * 4096); wait_m = 1'b1;
                end else begin
                    pay_m = ref_decode(hd); loaded = 1'b1;
                end
            end else begin
                wait_m = 1'b0; loaded = 1'b1;
                if (hd[15:11] == 5'b11111) begin
                    void'(q_m.pop_front());
                    pay_m = zero_pay();
                    pay_m.uop = 5'd11; pay_m.num = hi_m + 32'(hd[10:0]) * 32'd2;
                    pay_m.dst = 4'd14; pay_m.wr = 1'b1; pay_m.cond = 4'hE;
                end else begin
                    pay_m = undef_pay();
                end
            end
        end
        if (loaded) ov_m = 1'b1;
        else if (rdy) ov_m = 1'b0;
        if (push) q_m.push_back(h);
    endtask

    task automatic compare_all();
        check("in_ready", in_ready, q_m.size() < DEPTH);
        check("out_valid", out_valid, ov_m);
        check("uop", uop, pay_m.uop);
        check("num", num, pay_m.num);
        check("sel", {sel_p0, sel_p1, sel_in}, {pay_m.p0, pay_m.p1, pay_m.dst});
        check("ctl", {num_to_rhs, wr_en, cond, explose}, {pay_m.rhs, pay_m.wr, pay_m.cond, pay_m.ex});
    endtask

    task automatic cycle(input logic v, input logic [15:0] h, input logic rdy, input logic fl);
        in_valid = v; in_instr = h; out_ready = rdy; flush = fl;
        model_step(v, h, rdy, fl);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_until_accepted(input logic [15:0] h, input logic rdy);
        bit acc;
        for (int k = 0; k < 8; k++) begin
            acc = (q_m.size() < DEPTH);
            cycle(1'b1, h, rdy, 1'b0);
            if (acc) break;
        end
    endtask

    task automatic mid_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_valid", out_valid, 1'b0);
        check("rst_uop", uop, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 11))
            0: return r;
            1: return {6'b000110, r[9:0]};
            2: return {6'b000111, r[9:0]};
            3: return {5'b00000, r[10:0]};
            4: return {3'b001, r[12:0]};
            5: return {10'b0100000001, r[5:0]};
            6: return {4'b0110, r[11:0]};
            7: return {5'b11100, r[10:0]};
            8: return {4'b1101, r[11:0]};
            9, 10: return {5'b11110, r[10:0]};
            default: return {5'b11111, r[10:0]};
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        // Single ADD register form.
        cycle(1'b1, 16'h1842, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp1_valid", out_valid, 1'b1);
        check("tp1_uop", uop, 5'd1);
        check("tp1_sel", {sel_p0, sel_p1, sel_in}, 12'h102);
        check("tp1_wr_ex", {wr_en, explose}, 2'b10);

        // MOV imm then BCOND back-to-back.
        cycle(1'b1, 16'h235A, 1'b1, 1'b0);
        cycle(1'b1, 16'hD1FE, 1'b1, 1'b0);
        check("tp2_mov", {uop, num, sel_in, num_to_rhs}, {5'd3, 32'h5A, 4'd3, 1'b1});
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp2_bcond", {uop, cond, num}, {5'd10, 4'd1, 32'hFFFFFFFC});

        // BL pair, then prefix followed by a non-suffix.
        cycle(1'b1, 16'hF000, 1'b1, 1'b0);
        cycle(1'b1, 16'hF802, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp3_bl", {uop, num, sel_in, wr_en}, {5'd11, 32'd4, 4'd14, 1'b1});
        cycle(1'b1, 16'hF000, 1'b1, 1'b0);
        cycle(1'b1, 16'h1842, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp3_undef", {uop, explose}, {5'd31, 1'b1});
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp3_add", uop, 5'd1);

        // Back-pressure: three accepted, fourth waits for space.
        cycle(1'b1, 16'h1842, 1'b0, 1'b0);
        cycle(1'b1, 16'h235A, 1'b0, 1'b0);
        cycle(1'b1, 16'h4041, 1'b0, 1'b0);
        check("tp4_full", in_ready, 1'b0);
        cycle(1'b1, 16'h2001, 1'b0, 1'b0);
        check("tp4_stable", {out_valid, uop}, {1'b1, 5'd1});
        push_until_accepted(16'h2001, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush drops a pending BL prefix.
        cycle(1'b1, 16'hF000, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        cycle(1'b1, 16'h235A, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("tp5_mov", {uop, explose}, {5'd3, 1'b0});
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Undefined slot, EOR, then reset mid-stream.
        cycle(1'b1, 16'hDE00, 1'b1, 1'b0);
        cycle(1'b1, 16'h4041, 1'b1, 1'b0);
        check("tp6_undef", {uop, explose}, {5'd31, 1'b1});
        cycle(1'b1, 16'h1842, 1'b1, 1'b0);
        check("tp6_eor", {uop, sel_p0, sel_in}, {5'd5, 4'd0, 4'd1});
        cycle(1'b1, 16'h235A, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        mid_reset();

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) mid_reset();
            else cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
                       $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
